// File: rtl/snd_vrc6_pkg.sv
// Shared types, constants and helpers for the VRC6 sound register write scheduler.
package snd_vrc6_pkg;

  typedef enum logic [2:0] {IDLE, MUTE, FETCH, WRITE, ENABLE} state_t;

  localparam int NUM_REGS = 9;
  localparam int REG_EN_BIT = 7;
  localparam logic [2:0] CHAN_BASE_NIB [3] = '{3'd1, 3'd2, 3'd3};
  localparam logic [7:0] EN_CLR_MASK = ~(8'd1 << REG_EN_BIT);

  function automatic logic [3:0] reg_index(input logic [1:0] chan, input logic [1:0] sel);
    return 4'(chan) * 4'd3 + 4'(sel);
  endfunction

  // reg2 of each channel carries the channel enable bit
  function automatic logic is_en_idx(input logic [3:0] idx);
    return (idx == 4'd2) || (idx == 4'd5) || (idx == 4'd8);
  endfunction

  function automatic logic [1:0] en_chan(input logic [3:0] idx);
    return (idx < 4'd3) ? 2'd0 : (idx < 4'd6) ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/snd_vrc6_cpu_dec.sv
// Decodes a CPU bus cycle into a VRC6 sound register write hit and register index.
module snd_vrc6_cpu_dec
  import snd_vrc6_pkg::*;
(
  input  logic [3:0] addr_hi,
  input  logic       rw,
  input  logic [1:0] reg_sel,
  output logic       hit,
  output logic [3:0] idx
);

  logic       nib_hit;
  logic [1:0] chan;

  always_comb begin
    nib_hit = 1'b0;
    chan    = 2'd0;
    for (int c = 0; c < 3; c++) begin
      if (addr_hi[2:0] == CHAN_BASE_NIB[c]) begin
        nib_hit = 1'b1;
        chan    = 2'(c);
      end
    end
    hit = addr_hi[3] & ~rw & nib_hit & (reg_sel != 2'd3);
    idx = hit ? reg_index(chan, reg_sel) : 4'd0;
  end

endmodule

// File: rtl/snd_vrc6_restore_sched.sv
// VRC6 sound register write scheduler: merges CPU writes with a mute/load/enable savestate restore.
// Optional SNDVRC6_READBACK_EN: full 9-entry shadow with rd_idx/rd_data readback port.
module snd_vrc6_restore_sched
  import snd_vrc6_pkg::*;
#(
  parameter int SRC_TIMEOUT = 255
) (
  input  logic        m2,
  input  logic        map_rst_n,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_data,
  input  logic [1:0]  chr_reg_addr,
  input  logic        start,
  output logic        src_req,
  output logic [3:0]  src_idx,
  input  logic        src_ack,
  input  logic [7:0]  src_data,
  output logic        reg_we,
  output logic [3:0]  reg_idx,
  output logic [7:0]  reg_data,
  output logic        busy,
  output logic        done,
  output logic        timeout
`ifdef SNDVRC6_READBACK_EN
  ,
  input  logic [3:0]  rd_idx,
  output logic [7:0]  rd_data
`endif
);

  state_t      state, state_nx;
  logic [3:0]  step, step_nx;
  logic [7:0]  wr_data_q;
  logic [7:0]  en_latch [3];
  logic [15:0] tmo_cnt;
  logic        done_q, timeout_q;
  logic        cpu_hit, slot_free, tmo_expired;
  logic [3:0]  cpu_idx;
  logic        fsm_we, ack_take, en_store, done_set, tmo_set;
  logic [3:0]  fsm_idx;
  logic [7:0]  fsm_data, mute_src;
  logic        unused_addr;

  assign unused_addr = ^cpu_addr[11:0];

  snd_vrc6_cpu_dec u_dec (
    .addr_hi (cpu_addr[15:12]),
    .rw      (cpu_rw),
    .reg_sel (chr_reg_addr),
    .hit     (cpu_hit),
    .idx     (cpu_idx)
  );

  assign slot_free   = ~cpu_hit;
  assign tmo_expired = (SRC_TIMEOUT != 0) && (tmo_cnt == 16'(SRC_TIMEOUT - 1));

  // The CPU owns the write port whenever it writes; a stalled FSM write simply retries
  assign reg_we   = cpu_hit | fsm_we;
  assign reg_idx  = cpu_hit ? cpu_idx  : fsm_idx;
  assign reg_data = cpu_hit ? cpu_data : fsm_data;
  assign busy     = (state != IDLE);
  assign done     = done_q;
  assign timeout  = timeout_q;

`ifdef SNDVRC6_READBACK_EN
  logic [7:0] shadow [NUM_REGS];

  always_ff @(negedge m2 or negedge map_rst_n) begin
    if (!map_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) shadow[i] <= 8'd0;
    end else if (reg_we) begin
      shadow[reg_idx] <= reg_data;
    end
  end

  assign mute_src = shadow[reg_index(step[1:0], 2'd2)];
  assign rd_data  = (rd_idx < 4'(NUM_REGS)) ? shadow[rd_idx] : 8'd0;
`else
  logic [7:0] shadow_en [3];

  always_ff @(negedge m2 or negedge map_rst_n) begin
    if (!map_rst_n) begin
      for (int i = 0; i < 3; i++) shadow_en[i] <= 8'd0;
    end else if (reg_we && is_en_idx(reg_idx)) begin
      shadow_en[en_chan(reg_idx)] <= reg_data;
    end
  end

  assign mute_src = shadow_en[step[1:0]];
`endif

  always_comb begin
    state_nx = state;
    step_nx  = step;
    fsm_we   = 1'b0;
    fsm_idx  = 4'd0;
    fsm_data = 8'd0;
    src_req  = 1'b0;
    src_idx  = 4'd0;
    ack_take = 1'b0;
    en_store = 1'b0;
    done_set = 1'b0;
    tmo_set  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = MUTE;
          step_nx  = 4'd0;
        end
      end
      MUTE: begin
        fsm_we   = 1'b1;
        fsm_idx  = reg_index(step[1:0], 2'd2);
        fsm_data = mute_src & EN_CLR_MASK;
        if (slot_free) begin
          if (step == 4'd2) begin
            state_nx = FETCH;
            step_nx  = 4'd0;
          end else begin
            step_nx = step + 4'd1;
          end
        end
      end
      FETCH: begin
        src_req = 1'b1;
        src_idx = step;
        if (src_ack) begin
          ack_take = 1'b1;
          state_nx = WRITE;
        end else if (tmo_expired) begin
          tmo_set  = 1'b1;
          state_nx = IDLE;
          step_nx  = 4'd0;
        end
      end
      WRITE: begin
        // Enable bits stay cleared until every register is loaded
        fsm_we   = 1'b1;
        fsm_idx  = step;
        fsm_data = is_en_idx(step) ? (wr_data_q & EN_CLR_MASK) : wr_data_q;
        if (slot_free) begin
          en_store = is_en_idx(step);
          if (step == 4'(NUM_REGS - 1)) begin
            state_nx = ENABLE;
            step_nx  = 4'd0;
          end else begin
            state_nx = FETCH;
            step_nx  = step + 4'd1;
          end
        end
      end
      ENABLE: begin
        fsm_we   = 1'b1;
        fsm_idx  = reg_index(step[1:0], 2'd2);
        fsm_data = en_latch[step[1:0]];
        if (slot_free) begin
          if (step == 4'd2) begin
            state_nx = IDLE;
            step_nx  = 4'd0;
            done_set = 1'b1;
          end else begin
            step_nx = step + 4'd1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        step_nx  = 4'd0;
      end
    endcase
  end

  always_ff @(negedge m2 or negedge map_rst_n) begin
    if (!map_rst_n) begin
      state     <= IDLE;
      step      <= 4'd0;
      wr_data_q <= 8'd0;
      tmo_cnt   <= 16'd0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      for (int i = 0; i < 3; i++) en_latch[i] <= 8'd0;
    end else begin
      state     <= state_nx;
      step      <= step_nx;
      done_q    <= done_set;
      timeout_q <= tmo_set;
      if (ack_take) wr_data_q <= src_data;
      if (en_store) en_latch[en_chan(step)] <= wr_data_q;
      tmo_cnt <= (state == FETCH && state_nx == FETCH) ? 16'(tmo_cnt + 16'd1) : 16'd0;
    end
  end

endmodule

// File: tb/tb_snd_vrc6_restore_sched.sv
// Testbench for snd_vrc6_restore_sched: directed and random traffic checked against an op-list reference model.
`timescale 1ns/1ps
module tb_snd_vrc6_restore_sched;

  localparam int TMO   = 4;
  localparam int NOACK = 1000;

  logic        m2 = 1'b1;
  logic        map_rst_n = 1'b1;
  logic [15:0] cpu_addr = 16'd0;
  logic        cpu_rw = 1'b1;
  logic [7:0]  cpu_data = 8'd0;
  logic [1:0]  chr_reg_addr = 2'd0;
  logic        start = 1'b0;
  logic        src_req;
  logic [3:0]  src_idx;
  logic        src_ack = 1'b0;
  logic [7:0]  src_data = 8'd0;
  logic        reg_we;
  logic [3:0]  reg_idx;
  logic [7:0]  reg_data;
  logic        busy, done, timeout;
`ifdef SNDVRC6_READBACK_EN
  logic [3:0]  rd_idx = 4'd0;
  logic [7:0]  rd_data;
`endif

  always #5 m2 = ~m2;

  snd_vrc6_restore_sched #(.SRC_TIMEOUT(TMO)) dut (
    .m2           (m2),
    .map_rst_n    (map_rst_n),
    .cpu_addr     (cpu_addr),
    .cpu_rw       (cpu_rw),
    .cpu_data     (cpu_data),
    .chr_reg_addr (chr_reg_addr),
    .start        (start),
    .src_req      (src_req),
    .src_idx      (src_idx),
    .src_ack      (src_ack),
    .src_data     (src_data),
    .reg_we       (reg_we),
    .reg_idx      (reg_idx),
    .reg_data     (reg_data),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout)
`ifdef SNDVRC6_READBACK_EN
    ,
    .rd_idx       (rd_idx),
    .rd_data      (rd_data)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a restore is a list of 24 ops (3 mutes, 9 fetch/write pairs, 3 enables)
  logic [7:0] mShadow [9];
  logic [7:0] mFetched [9];
  bit mActive, mDoneNext, mTmoNext;
  int mOp, mWait, mDelay;
  int noAckFrom = 9;
  int delayMax = 0;
  int srcMode = 0;
  int preemptAtOp = -1;

  bit sCpu, sRw, sStart;
  logic [15:0] sAddr;
  logic [7:0] sData;
  logic [1:0] sSel;
  logic [11:0] wrLog [$];

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit isFetchOp(input int op);
    return (op >= 3) && (op < 21) && (((op - 3) % 2) == 0);
  endfunction

  function automatic logic [7:0] srcValue(input int i);
    case (srcMode)
      1: return 8'(8'h10 + i);
      2: return 8'(8'h80 | i);
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic modelStep();
    int nib, cIdx, eIdx, eSidx, prevOp;
    bit hit, eWe, eReq;
    logic [7:0] eData;
    eWe = 0; eIdx = 0; eData = 8'd0; eReq = 0; eSidx = 0;
    nib  = int'(cpu_addr[14:12]);
    hit  = cpu_addr[15] && !cpu_rw && nib >= 1 && nib <= 3 && chr_reg_addr != 2'd3;
    cIdx = (nib - 1) * 3 + int'(chr_reg_addr);
    checkOutput("busy", 16'(busy), 16'(mActive));
    checkOutput("done", 16'(done), 16'(mDoneNext));
    checkOutput("timeout", 16'(timeout), 16'(mTmoNext));
`ifdef SNDVRC6_READBACK_EN
    checkOutput("rd_data", 16'(rd_data), (rd_idx > 4'd8) ? 16'd0 : 16'(mShadow[rd_idx]));
`endif
    mDoneNext = 0;
    mTmoNext  = 0;
    prevOp    = mOp;
    if (mActive) begin
      if (isFetchOp(mOp)) begin
        eReq  = 1;
        eSidx = (mOp - 3) / 2;
        if (src_ack) begin
          mFetched[eSidx] = src_data;
          mOp++;
        end else begin
          mWait++;
          if (mWait == TMO) begin
            mActive  = 0;
            mTmoNext = 1;
          end
        end
      end else begin
        if (mOp < 3) begin
          eIdx  = mOp * 3 + 2;
          eData = mShadow[eIdx] & 8'h7F;
        end else if (mOp < 21) begin
          eIdx  = (mOp - 4) / 2;
          eData = ((eIdx % 3) == 2) ? (mFetched[eIdx] & 8'h7F) : mFetched[eIdx];
        end else begin
          eIdx  = (mOp - 21) * 3 + 2;
          eData = mFetched[eIdx];
        end
        eWe = 1;
        if (!hit) begin
          mOp++;
          if (mOp == 24) begin
            mActive   = 0;
            mDoneNext = 1;
          end
        end
      end
      if (mActive && mOp != prevOp && isFetchOp(mOp)) begin
        mWait  = 0;
        mDelay = (((mOp - 3) / 2) >= noAckFrom) ? NOACK : $urandom_range(0, delayMax);
      end
    end else if (start) begin
      mActive = 1;
      mOp     = 0;
    end
    if (hit) begin
      eWe   = 1;
      eIdx  = cIdx;
      eData = cpu_data;
    end
    checkOutput("reg_we", 16'(reg_we), 16'(eWe));
    checkOutput("reg_idx", 16'(reg_idx), 16'(eIdx));
    checkOutput("reg_data", 16'(reg_data), 16'(eData));
    checkOutput("src_req", 16'(src_req), 16'(eReq));
    checkOutput("src_idx", 16'(src_idx), 16'(eSidx));
    if (eWe) mShadow[eIdx] = eData;
  endtask

  // One bus cycle: drive inputs just after the active (falling) edge, check mid-cycle
  task automatic applyStimulus();
    @(negedge m2);
    #1;
    if (preemptAtOp >= 0 && mActive && mOp == preemptAtOp) begin
      sCpu = 1; sAddr = 16'h9000; sRw = 0; sData = 8'h3F; sSel = 2'd0;
      preemptAtOp = -1;
    end
    if (sCpu) begin
      cpu_addr = sAddr; cpu_rw = sRw; cpu_data = sData; chr_reg_addr = sSel;
    end else begin
      cpu_addr = 16'($urandom); cpu_rw = 1'b1; cpu_data = 8'($urandom);
      chr_reg_addr = 2'($urandom);
    end
    start = sStart;
    if (mActive && isFetchOp(mOp)) begin
      src_ack  = (mWait >= mDelay);
      src_data = src_ack ? srcValue((mOp - 3) / 2) : 8'($urandom);
    end else begin
      src_ack  = ($urandom_range(0, 3) == 0);
      src_data = 8'($urandom);
    end
`ifdef SNDVRC6_READBACK_EN
    rd_idx = 4'($urandom);
`endif
    #2;
    modelStep();
    sCpu = 0;
    sStart = 0;
  endtask

  task automatic cpuWrite(input logic [15:0] addr, input logic [1:0] sel, input logic [7:0] data);
    sCpu = 1; sAddr = addr; sRw = 0; sSel = sel; sData = data;
    applyStimulus();
  endtask

  task automatic applyReset(input bit checkPre);
    @(negedge m2);
    #1;
    if (checkPre) begin
      checkOutput("rst_pre_req", 16'(src_req), 16'd1);
      checkOutput("rst_pre_idx", 16'(src_idx), 16'd5);
    end
    start = 1'b0; src_ack = 1'b0; cpu_rw = 1'b1;
    map_rst_n = 1'b0;
    #1;
    checkOutput("rst_src_req", 16'(src_req), 16'd0);
    checkOutput("rst_busy", 16'(busy), 16'd0);
    for (int i = 0; i < 9; i++) mShadow[i] = 8'd0;
    mActive = 0; mDoneNext = 0; mTmoNext = 0;
    repeat (2) @(negedge m2);
    #1;
    map_rst_n = 1'b1;
  endtask

  task automatic runRestore(input int maxCycles, output int busyCnt, output int reqCnt);
    int cyc;
    busyCnt = 0; reqCnt = 0; cyc = 0;
    wrLog.delete();
    sStart = 1;
    do begin
      applyStimulus();
      if (busy) busyCnt++;
      if (src_req) reqCnt++;
      if (reg_we) wrLog.push_back({reg_idx, reg_data});
      cyc++;
    end while (mActive && cyc < maxCycles);
    if (mActive) checkOutput("restore_bound", 16'(cyc), 16'(maxCycles + 1));
    applyStimulus();
    if (busy) busyCnt++;
  endtask

  initial begin
    int bc, rc, cyc;
    sCpu = 0; sStart = 0; sRw = 1; sAddr = 16'd0; sData = 8'd0; sSel = 2'd0;
    mActive = 0; mOp = 0; mWait = 0; mDelay = 0;
    for (int i = 0; i < 9; i++) mFetched[i] = 8'd0;
    applyReset(0);
    repeat (3) applyStimulus();

    cpuWrite(16'hA001, 2'd1, 8'h5A);
    checkOutput("a001_idx", 16'(reg_idx), 16'd4);
    checkOutput("a001_data", 16'(reg_data), 16'h5A);

    cpuWrite(16'h9002, 2'd2, 8'h85);
    cpuWrite(16'hA002, 2'd2, 8'h8F);
    cpuWrite(16'hB002, 2'd2, 8'h83);
    srcMode = 1; delayMax = 0; noAckFrom = 9;
    runRestore(60, bc, rc);
    checkOutput("mute0", 16'(wrLog[0]), 16'h205);
    checkOutput("mute1", 16'(wrLog[1]), 16'h50F);
    checkOutput("mute2", 16'(wrLog[2]), 16'h803);
    checkOutput("load_idx2", 16'(wrLog[5]), 16'h212);
    checkOutput("enable_idx8", 16'(wrLog[14]), 16'h818);
    checkOutput("min_len", 16'(bc), 16'd24);

    srcMode = 2;
    runRestore(60, bc, rc);
    checkOutput("load_idx2_en", 16'(wrLog[5]), 16'h202);
    checkOutput("load_idx8_en", 16'(wrLog[11]), 16'h808);
    checkOutput("enable_idx2", 16'(wrLog[12]), 16'h282);
    checkOutput("enable_idx8b", 16'(wrLog[14]), 16'h888);

    srcMode = 1; preemptAtOp = 12;
    runRestore(60, bc, rc);
    checkOutput("preempt_cpu", 16'(wrLog[7]), 16'h03F);
    checkOutput("preempt_fsm", 16'(wrLog[8]), 16'h414);
    checkOutput("preempt_len", 16'(bc), 16'd25);

    noAckFrom = 0;
    runRestore(60, bc, rc);
    checkOutput("tmo_req_cycles", 16'(rc), 16'd4);
    checkOutput("tmo_writes", 16'(wrLog.size()), 16'd3);

    noAckFrom = 9; sStart = 1; applyStimulus();
    cyc = 0;
    while (!(mActive && mOp == 13) && cyc < 40) begin
      applyStimulus();
      cyc++;
    end
    if (cyc >= 40) checkOutput("reach_fetch5", 16'(cyc), 16'd0);
    applyReset(1);
    runRestore(60, bc, rc);
    checkOutput("post_rst_len", 16'(bc), 16'd24);

    srcMode = 0; delayMax = 3;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        sCpu  = 1;
        sAddr = 16'($urandom);
        if ($urandom_range(0, 3) != 0) sAddr[15] = 1'b1;
        sAddr[14:12] = 3'($urandom_range(0, 4));
        sRw   = ($urandom_range(0, 4) == 0);
        sSel  = 2'($urandom_range(0, 3));
        sData = 8'($urandom);
      end
      if ($urandom_range(0, 24) == 0) begin
        sStart = 1;
        if (!mActive) noAckFrom = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 8) : 9;
      end
      applyStimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
